aes_mode_engine: RTL

Block-cipher mode controller wrapping one `Encrypt_TopLevel` AES-128 encryption core instance. Accepts a stream of 128-bit blocks through a valid/ready input FIFO and applies ECB, CBC or CTR mode around the core. Returns results on a valid/ready output port. Sits between the host-side data path and the existing encrypt core, so software can stream multi-block messages without per-block key/IV handling.

---
 rtl/aes_mode_engine_if.sv | 30 +++
 rtl/aes_mode_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine_if.sv
// Host-side handshake bundle for aes_mode_engine.
//   Session control: start, mode, key, iv
//   Status:          busy, err
//   Input stream:    in_valid / in_ready / in_data   (128-bit blocks)
//   Output stream:   out_valid / out_ready / out_data (128-bit blocks)
// The master drives the session and both stream sides. The slave is the engine.
interface aes_mode_engine_if;
    logic         start;
    logic [1:0]   mode;
    logic [127:0] key;
    logic [127:0] iv;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         err;

    modport master (
        output start, mode, key, iv, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, err
    );

    modport slave (
        input  start, mode, key, iv, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, err
    );
endinterface

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: streams 128-bit blocks through one iterative AES-128 encrypt core
// in ECB, CBC or CTR mode.
//   clk, rst_n : single clock, asynchronous active-low reset
//   host       : aes_mode_engine_if.slave (session control, in/out streams, busy/err)
// Parameters: DEPTH = input FIFO entries (power of 2, >= 2). CTR_W = counter bits that
// CTR mode increments.
// Encrypt_TopLevel below is the iterative AES-128 core. It runs one round per clock.
// On E_int it loads the plaintext and key. After 10 rounds it pulses E_done for one
// cycle, and ciphertext then holds the result until the next E_int.
module aes_mode_engine #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CTR_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    aes_mode_engine_if.slave host
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [127:0] CtrMask =
        (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

    localparam logic [1:0] ModeEcb  = 2'd0;
    localparam logic [1:0] ModeCbc  = 2'd1;
    localparam logic [1:0] ModeCtr  = 2'd2;
    localparam logic [1:0] ModeRsvd = 2'd3;

    typedef enum logic [1:0] {StIdle, StWait, StFire, StRun} state_e;

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  chain_q, chain_d;
    logic          err_q, err_d;
    logic [127:0]  core_in_q, core_in_d;
    logic [127:0]  data_q, data_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_data_q, out_data_d;
    logic          done_q;

    logic [127:0]  mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;

    logic          full, empty, push, pop;
    logic [127:0]  head;
    logic          e_int, core_done, core_edge;
    logic [127:0]  core_ct;

    assign head  = mem_q[rptr_q];
    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);
    // Pop only while the output register is free, so one block is in flight at a time.
    assign pop   = (state_q == StWait) && !empty && !out_valid_q;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign host.in_ready = (state_q != StIdle) && (!full || pop);
    assign push  = host.in_valid && host.in_ready;

    assign e_int     = (state_q == StFire);
    assign core_edge = core_done && !done_q;

    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;
    assign host.busy      = (state_q != StIdle);
    assign host.err       = err_q;

    Encrypt_TopLevel u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .E_int      (e_int),
        .plaintext  (core_in_q),
        .key        (key_q),
        .ciphertext (core_ct),
        .E_done     (core_done)
    );

    // FIFO storage carries no reset; the pointers and the count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= host.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= ModeEcb;
            key_q       <= '0;
            chain_q     <= '0;
            err_q       <= 1'b0;
            core_in_q   <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            chain_q     <= chain_d;
            err_q       <= err_d;
            core_in_q   <= core_in_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= core_done;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        key_d       = key_q;
        chain_d     = chain_q;
        err_d       = err_q;
        core_in_d   = core_in_q;
        data_d      = data_q;
        out_valid_d = out_valid_q && !host.out_ready;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    if (host.mode == ModeRsvd) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        mode_d  = host.mode;
                        key_d   = host.key;
                        chain_d = host.iv;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (pop) begin
                    data_d = head;
                    case (mode_q)
                        ModeEcb: core_in_d = head;
                        ModeCbc: core_in_d = head ^ chain_q;
                        ModeCtr: core_in_d = chain_q;
                        default: core_in_d = head;
                    endcase
                    state_d = StFire;
                end else if (empty && !host.start && !out_valid_q && !push) begin
                    state_d = StIdle;
                end
            end
            StFire: state_d = StRun;
            StRun: begin
                if (core_edge) begin
                    out_valid_d = 1'b1;
                    case (mode_q)
                        ModeCbc: begin
                            out_data_d = core_ct;
                            chain_d    = core_ct;
                        end
                        ModeCtr: begin
                            out_data_d = data_q ^ core_ct;
                            // Only the low CTR_W bits count; the upper bits never change.
                            chain_d = ((chain_q + 128'd1) & CtrMask) | (chain_q & ~CtrMask);
                        end
                        default: out_data_d = core_ct;
                    endcase
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

module Encrypt_TopLevel (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         E_int,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic [127:0] ciphertext,
    output logic         E_done
);
    logic [127:0] state_q, rk_q;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic         run_q, done_q;
    logic [127:0] rk_next, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box = affine(b^254); b^254 is the GF(2^8) inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = b;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i sits at [127-8i -: 8]; state is column-major, so byte 4c+r is row r, column c.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] sb, sr, o;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    assign rk_next    = next_key(rk_q, rcon_q);
    assign round_out  = aes_round(state_q, rk_next, round_q == 4'd10);
    assign ciphertext = state_q;
    assign E_done     = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            rk_q    <= '0;
            rcon_q  <= 8'h01;
            round_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (E_int) begin
                state_q <= plaintext ^ key;
                rk_q    <= key;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
                run_q   <= 1'b1;
            end else if (run_q) begin
                state_q <= round_out;
                rk_q    <= rk_next;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                if (round_q == 4'd10) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule
